pattern_gen: RTL and testbench

Parametrised test-data source that feeds words to the transmit path one at a time, using a valid/ready handshake. It replaces the free-running increment-on-done counter. On each start it emits a burst of a programmed length, in one of four runtime-selectable patterns: increment, decrement, LFSR or walking-one. It then pulses a completion flag. It sits between the control/stimulus logic and the serial transmitter, and `i_ready` is driven from the transmitter's accept/done indication.

---
 rtl/pattern_gen.sv | 116 +++++++++++
 tb/tb_pattern_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// Burst test-data source: emits a programmed number of words over valid/ready
// in increment, decrement, LFSR or walking-one order, then pulses o_done.
module pattern_gen #(
  parameter int                DATA_W = 10,
  parameter int                LEN_W  = 16,
  parameter int unsigned       SEED   = 1,
  parameter logic [DATA_W-1:0] TAPS   = 10'h240
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic [LEN_W-1:0]  o_count
);

  localparam logic [1:0] MODE_INC  = 2'd0;
  localparam logic [1:0] MODE_DEC  = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;

  // An all-zero LFSR state would lock up, so a zero seed falls back to 1.
  localparam logic [DATA_W-1:0] SEED_M    = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] SEED_INIT = (SEED_M == '0) ? DATA_W'(1) : SEED_M;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_mode;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_count;
  logic [DATA_W-1:0]  r_data;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic               w_xfer;
  logic               w_load;
  logic [LEN_W-1:0]   w_count_inc;

  function automatic logic [DATA_W-1:0] f_first(input logic [1:0] mode);
    case (mode)
      MODE_INC:  f_first = '0;
      MODE_DEC:  f_first = '1;
      MODE_LFSR: f_first = SEED_INIT;
      default:   f_first = DATA_W'(1);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] f_next(input logic [1:0] mode,
                                               input logic [DATA_W-1:0] d);
    case (mode)
      MODE_INC:  f_next = d + DATA_W'(1);
      MODE_DEC:  f_next = d - DATA_W'(1);
      MODE_LFSR: f_next = {d[DATA_W-2:0], ^(d & TAPS)};
      default:   f_next = {d[DATA_W-2:0], d[DATA_W-1]};
    endcase
  endfunction

  assign w_xfer      = (r_state == S_RUN) && i_ready;
  assign w_load      = (r_state == S_IDLE) && i_start;
  assign w_count_inc = r_count + LEN_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = (i_len == '0) ? S_DONE : S_RUN;
      S_RUN:  if (w_xfer && (w_count_inc == r_len)) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so every output is a flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == S_RUN);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode  <= MODE_INC;
      r_len   <= '0;
      r_count <= '0;
      r_data  <= '0;
    end else if (w_load) begin
      r_mode  <= i_mode;
      r_len   <= i_len;
      r_count <= '0;
      r_data  <= f_first(i_mode);
    end else if (w_xfer) begin
      r_count <= w_count_inc;
      r_data  <= f_next(r_mode, r_data);
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_count = r_count;

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: a word-index model predicts every output each cycle,
// and directed bursts compare the transferred words against literal sequences.
module tb_pattern_gen;

  localparam int DW   = 10;
  localparam int LW   = 16;
  localparam int MASK = (1 << DW) - 1;
  localparam int TAPV = 'h240;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [1:0]    i_mode = 2'd0;
  logic [LW-1:0] i_len = '0;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_busy;
  logic          o_done;
  logic [LW-1:0] o_count;

  pattern_gen #(.DATA_W(DW), .LEN_W(LW), .SEED(1), .TAPS(10'h240)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
    .i_len(i_len), .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid),
    .o_busy(o_busy), .o_done(o_done), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;
  int lfsr_tab[1023];
  int got[$];
  int seen[$];

  // Model: where we are in the burst, expressed as a word index.
  int m_phase = 0;   // 0 idle, 1 offering words, 2 completion cycle
  int m_k = 0;
  int m_len = 0;
  int m_mode = 0;
  bit m_started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int word(input int mode, input int k);
    case (mode)
      0:       return k & MASK;
      1:       return MASK - (k & MASK);
      2:       return lfsr_tab[k % 1023];
      default: return 1 << (k % DW);
    endcase
  endfunction

  always @(posedge i_clk) begin
    if (i_rst) begin
      m_phase <= 0; m_k <= 0; m_started <= 0;
    end else begin
      case (m_phase)
        0: if (i_start) begin
             m_mode <= int'(i_mode); m_len <= int'(i_len); m_k <= 0; m_started <= 1;
             m_phase <= (i_len == 0) ? 2 : 1;
           end
        1: if (i_ready) begin
             m_k <= m_k + 1;
             if (m_k + 1 == m_len) m_phase <= 2;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("data",  32'(o_data),  m_started ? 32'(word(m_mode, m_k)) : 32'd0);
      chk("valid", 32'(o_valid), 32'(m_phase == 1));
      chk("busy",  32'(o_busy),  32'(m_phase != 0));
      chk("done",  32'(o_done),  32'(m_phase == 2));
      chk("count", 32'(o_count), 32'(m_k));
      if (o_valid === 1'b1) seen.push_back(int'(o_data));
      if (o_valid === 1'b1 && i_ready) got.push_back(int'(o_data));
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (o_busy === 1'b0) return;
      step();
    end
    chk("idle_timeout", 32'(o_busy), 32'd0);
  endtask

  task automatic burst(input int mode, input int len);
    got.delete(); seen.delete();
    i_mode = 2'(mode); i_len = LW'(len); i_ready = 1'b1; i_start = 1'b1;
    step();
    i_start = 1'b0;
    wait_idle(len + 10);
  endtask

  task automatic chk_got(input string name, input int e[$]);
    chk({name, "_size"}, 32'(got.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < got.size(); i++)
      chk(name, 32'(got[i]), 32'(e[i]));
  endtask

  initial begin
    int e[$];
    int v;
    int ones;
    v = 1;
    for (int i = 0; i < 1023; i++) begin
      lfsr_tab[i] = v;
      v = ((v << 1) & MASK) | ($countones(v & TAPV) & 1);
    end

    i_rst = 1'b1;
    step();
    chk_en = 1;
    step(); step();
    chk("rst_data", 32'(o_data), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_count", 32'(o_count), 0);
    i_rst = 1'b0;
    step();

    burst(0, 5);
    e = '{0, 1, 2, 3, 4};
    chk_got("inc5", e);
    chk("inc5_count", 32'(o_count), 5);

    got.delete(); seen.delete();
    i_mode = 2'd0; i_len = 16'd3; i_start = 1'b1; i_ready = 1'b0;
    step();
    i_start = 1'b0;
    e = '{1, 0, 0, 1, 1};
    foreach (e[i]) begin i_ready = e[i][0]; step(); end
    wait_idle(10);
    e = '{0, 1, 2};
    chk_got("bp_xfer", e);
    chk("bp_seen_size", 32'(seen.size()), 5);
    e = '{0, 1, 1, 1, 2};
    for (int i = 0; i < 5 && i < seen.size(); i++) chk("bp_seen", 32'(seen[i]), 32'(e[i]));
    chk("bp_count", 32'(o_count), 3);

    burst(0, 1026);
    chk("wrap_size", 32'(got.size()), 1026);
    if (got.size() == 1026) begin
      chk("wrap_a", 32'(got[1023]), 1023);
      chk("wrap_b", 32'(got[1024]), 0);
      chk("wrap_c", 32'(got[1025]), 1);
    end

    burst(1, 2);
    e = '{1023, 1022};
    chk_got("dec2", e);

    burst(2, 1024);
    chk("lfsr_size", 32'(got.size()), 1024);
    if (got.size() == 1024) begin
      e = '{1, 2, 4, 8, 16, 32, 64, 129, 258, 516, 9};
      for (int i = 0; i < 11; i++) chk("lfsr_head", 32'(got[i]), 32'(e[i]));
      ones = 0;
      for (int i = 1; i < 1023; i++) if (got[i] == 1) ones++;
      chk("lfsr_no_early_1", 32'(ones), 0);
      chk("lfsr_period", 32'(got[1023]), 1);
    end

    burst(3, 12);
    e = '{1, 2, 4, 8, 16, 32, 64, 128, 256, 512, 1, 2};
    chk_got("walk12", e);

    got.delete(); seen.delete();
    i_mode = 2'd0; i_len = 16'd0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("len0_done", 32'(o_done), 1);
    chk("len0_valid", 32'(o_valid), 0);
    step();
    chk("len0_idle", 32'(o_busy), 0);
    chk("len0_no_valid", 32'(seen.size()), 0);

    got.delete(); seen.delete();
    i_mode = 2'd0; i_len = 16'd8; i_ready = 1'b1; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step(); step();
    i_start = 1'b1; i_mode = 2'd1; i_len = 16'd2;
    step();
    i_start = 1'b0;
    wait_idle(20);
    e = '{0, 1, 2, 3, 4, 5, 6, 7};
    chk_got("start_in_run", e);
    chk("start_in_run_count", 32'(o_count), 8);

    got.delete(); seen.delete();
    i_mode = 2'd3; i_len = 16'd8; i_ready = 1'b1; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step(); step(); step();
    i_rst = 1'b1;
    step();
    chk("midrst_data", 32'(o_data), 0);
    chk("midrst_valid", 32'(o_valid), 0);
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_done", 32'(o_done), 0);
    chk("midrst_count", 32'(o_count), 0);
    i_rst = 1'b0;
    step();
    burst(3, 8);
    e = '{1, 2, 4, 8, 16, 32, 64, 128};
    chk_got("after_rst", e);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
